// File: rtl/rr_mux_pkg.sv
// Shared constants for the four-requester round-robin mux arbiter.
package rr_mux_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;
endpackage

// File: rtl/mux4.sv
// Generic four-input word mux.
module mux4 #(
  parameter int W = 32
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [1:0]   sel,
  output logic [W-1:0] y
);
  always_comb begin
    unique case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end
endmodule

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set request at or after ptr, wrapping modulo 4.
module rr_pick
  import rr_mux_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   win
);
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [SEL_W-1:0]     ofs;

  // Rotating right by ptr puts the highest-priority requester at bit 0.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[NUM_REQ-1:0];
  assign any = |req;

  always_comb begin
    ofs = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (rot[k]) ofs = SEL_W'(k);
  end

  assign win = ptr + ofs;
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter steering a shared 4:1 mux into a valid/ready output register.
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [data_width-1:0] in_data0,
  input  logic [data_width-1:0] in_data1,
  input  logic [data_width-1:0] in_data2,
  input  logic [data_width-1:0] in_data3,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [SEL_W-1:0]      select,
  output logic                  out_valid,
  output logic [data_width-1:0] out_data,
  output logic [SEL_W-1:0]      out_src,
  input  logic                  out_ready,
  output logic                  busy
);
  logic                  state, state_nxt;
  logic [SEL_W-1:0]      ptr, sel_q, win;
  logic                  any, can_load, load;
  logic [data_width-1:0] mux_data;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr),
    .any (any),
    .win (win)
  );

  assign can_load = (state == ST_EMPTY) || (out_valid && out_ready);
  assign load     = can_load && any && !reset;
  // With no requests the mux keeps pointing where it last pointed.
  assign select   = reset ? '0 : (any ? win : sel_q);
  assign busy     = out_valid || any;

  mux4 #(.W(data_width)) u_mux (
    .d0  (in_data0),
    .d1  (in_data1),
    .d2  (in_data2),
    .d3  (in_data3),
    .sel (select),
    .y   (mux_data)
  );

  always_comb begin
    gnt = '0;
    if (load) gnt[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (any) state_nxt = ST_FULL;
      ST_FULL:  if (out_ready && !any) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state == ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
      out_src  <= '0;
      ptr      <= '0;
      sel_q    <= '0;
    end else begin
      sel_q <= select;
      if (load) begin
        out_data <= mux_data;
        out_src  <= win;
        ptr      <= win + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Randomized bench for rr_mux_arbiter against a queue-free behavioural model, plus directed pins.
module tb_rr_mux_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] din [4];
  logic [3:0]  gnt;
  logic [1:0]  select;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_src;
  logic        out_ready;
  logic        busy;

  int tests = 0;
  int fails = 0;

  // behavioural model state
  int          m_ptr = 0;
  bit          m_full = 0;
  logic [31:0] m_data = '0;
  int          m_src = 0;
  int          m_sel = 0;
  bit          regs_ok = 0;

  logic [3:0]  g_gnt;
  logic [1:0]  g_sel;
  logic        g_busy;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.data_width(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .in_data0  (din[0]),
    .in_data1  (din[1]),
    .in_data2  (din[2]),
    .in_data3  (din[3]),
    .gnt       (gnt),
    .select    (select),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check, advance the model.
  task automatic cyc(input logic rst, input logic [3:0] r, input logic rdy);
    int  w;
    bit  found, can;
    logic [3:0] egnt;
    int  esel;
    reset = rst; req = r; out_ready = rdy;
    #1;
    if (regs_ok) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
      chk("out_data", out_data, m_data);
      chk("out_src", {30'd0, out_src}, m_src);
    end
    w = 0; found = 0;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (m_ptr + k) % 4;
      if (!found && r[idx]) begin w = idx; found = 1; end
    end
    can  = !m_full || rdy;
    egnt = (!rst && found && can) ? (4'b0001 << w) : 4'b0000;
    esel = rst ? 0 : (found ? w : m_sel);
    chk("gnt", {28'd0, gnt}, {28'd0, egnt});
    chk("select", {30'd0, select}, esel);
    if (regs_ok) chk("busy", {31'd0, busy}, {31'd0, (m_full || found)});
    g_gnt = gnt; g_sel = select; g_busy = busy;
    if (rst) begin
      m_ptr = 0; m_full = 0; m_data = '0; m_src = 0; m_sel = 0;
    end else begin
      m_sel = esel;
      if (found && can) begin
        m_data = din[w]; m_src = w; m_full = 1; m_ptr = (w + 1) % 4;
      end else if (m_full && rdy) begin
        m_full = 0;
      end
    end
    regs_ok = 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] seq [8];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
    seq[4] = 4'b0001; seq[5] = 4'b0010; seq[6] = 4'b0100; seq[7] = 4'b1000;
    for (int i = 0; i < 4; i++) din[i] = 32'h1000_0000 + i;
    reset = 1; req = 0; out_ready = 0;
    @(negedge clk);
    cyc(1, 4'b0000, 0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);

    // reset mid-transfer: load, hold under backpressure, reset
    cyc(0, 4'b0100, 0);
    cyc(0, 4'b0000, 0);
    chk("hold_valid", {31'd0, out_valid}, 32'd1);
    cyc(1, 4'b1111, 0);
    chk("rst2_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_data", out_data, 32'd0);

    // full contention from ptr=0
    for (int i = 0; i < 8; i++) begin
      cyc(0, 4'b1111, 1);
      chk("contend_gnt", {28'd0, g_gnt}, {28'd0, seq[i]});
      chk("contend_valid", {31'd0, out_valid}, 32'd1);
    end

    // backpressure: ptr=0, requesters 1 and 3
    cyc(0, 4'b1010, 1);
    chk("bp_first", {28'd0, g_gnt}, 32'b0010);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 4'b1010, 0);
      chk("bp_gnt", {28'd0, g_gnt}, 32'd0);
      chk("bp_data", out_data, 32'h1000_0001);
    end
    cyc(0, 4'b1010, 1);
    chk("bp_release", {28'd0, g_gnt}, 32'b1000);
    chk("bp_src", {30'd0, out_src}, 32'd3);

    // wrap-around
    cyc(0, 4'b1001, 1);
    chk("wrap0", {28'd0, g_gnt}, 32'b0001);
    cyc(0, 4'b1001, 1);
    chk("wrap3", {28'd0, g_gnt}, 32'b1000);

    // single requester
    din[2] = 32'hDEADBEEF;
    cyc(0, 4'b0100, 1);
    chk("single_gnt", {28'd0, g_gnt}, 32'b0100);
    chk("single_sel", {30'd0, g_sel}, 32'd2);
    chk("single_data", out_data, 32'hDEADBEEF);
    chk("single_src", {30'd0, out_src}, 32'd2);

    // drain to empty
    cyc(0, 4'b0000, 1);
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    cyc(0, 4'b0000, 1);
    chk("drain_busy", {31'd0, g_busy}, 32'd0);
    chk("idle_sel", {30'd0, g_sel}, 32'd2);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic       rst;
      logic [3:0] r;
      logic       rdy;
      for (int i = 0; i < 4; i++) din[i] = $urandom;
      rst = ($urandom_range(0, 199) == 0);
      r   = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
      rdy = ($urandom_range(0, 9) < 7);
      cyc(rst, r, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Four-requester round-robin arbiter that sequences a shared 4:1 datapath mux onto a single downstream bus, for example a shared register-file write port or a memory-write path.
- Chooses one requester per cycle, drives the 2-bit mux select, and captures the selected word into an output register.
- Presents the captured word downstream with a valid/ready handshake.
- Sits between up to four producers (ALU, memory, PC+4, immediate path) and one consumer.

Parameters:
- data_width, 32, width of each input word and of out_data.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request vector; req[i] set means in_data{i} is valid.
- in_data0  input  data_width  requester 0 word.
- in_data1  input  data_width  requester 1 word.
- in_data2  input  data_width  requester 2 word.
- in_data3  input  data_width  requester 3 word.
- gnt  output  4  one-hot acknowledge; gnt[i] high for exactly one cycle in the cycle in_data{i} is captured.
- select  output  2  mux select driven to the shared mux (00 picks data0 … 11 picks data3).
- out_valid  output  1  out_data holds an unconsumed word.
- out_data  output  data_width  registered winning word.
- out_src  output  2  index of the requester whose word is in out_data.
- out_ready  input  1  downstream accepts out_data when out_valid and out_ready are both high.
- busy  output  1  high when out_valid=1 or |req=1.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - out_valid=0, out_data=0, out_src=0, gnt=0, select=0.
  - Round-robin pointer ptr=0; state=EMPTY.
  - reset overrides all other inputs in the same cycle, and any held word is discarded.
- State machine, two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- can_load = (state==EMPTY) or (out_valid and out_ready).
- Arbitration (combinational):
  - Search req starting at index ptr, then ptr+1, ptr+2, ptr+3, with modulo-4 wrap.
  - The first set bit is winner w.
  - select=w whenever |req=1; otherwise select holds its last registered value.
- Load: if can_load and |req=1 at a clk edge:
  - out_data <= selected word, out_src <= w, out_valid <= 1.
  - gnt[w] is high during that cycle (combinational, qualified by can_load).
  - ptr <= (w+1) mod 4.
- Drain without refill: if out_valid and out_ready and req==0, then out_valid <= 0 and state -> EMPTY.
- Simultaneous drain and refill: the new word replaces the old one in the same edge with no bubble. This gives sustained throughput of 1 word/cycle.
- Backpressure: while state==FULL and out_ready=0:
  - out_data and out_src hold, gnt=0, ptr holds.
  - Requesters must keep req and data stable until they see gnt.
- Latency: req[i] at cycle N with the pipe empty gives gnt[i] in cycle N and out_valid=1 in cycle N+1.
- Fairness: with all four requesting continuously and out_ready=1, grants go 0,1,2,3,0,… Any persistently requesting source is granted within 4 accepted transfers.
- ptr changes only on a load. Requests dropped before grant are never issued.
- gnt is never asserted when can_load=0, and never has more than one bit set.
- Width rule: pointer arithmetic is 2-bit unsigned with natural wrap (3+1=0).

Decomposition:
- Shared package rr_mux_pkg:
  - NUM_REQ=4, SEL_W=2.
  - State encoding localparams ST_EMPTY=1'b0, ST_FULL=1'b1.
- Sub-module rr_pick: purely combinational rotate-priority encoder.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: any, win[1:0].
- The top level holds the FSM, ptr, the output register, and the select mux. The data mux is the team's existing four-input mux, instantiated with data_width.

Test Plan:
- Reset mid-transfer: out_valid=1 with out_ready=0, then reset for 1 cycle -> next cycle out_valid=0, out_data=0, gnt=0, ptr=0; req=4'b1111 then grants requester 0 first.
- Single requester:
  - Stimulus: req=4'b0100, in_data2=32'hDEADBEEF, out_ready=1.
  - Response: gnt=4'b0100 and select=2'b10 in cycle N; cycle N+1 out_valid=1, out_data=32'hDEADBEEF, out_src=2.
- Full contention: req=4'b1111, out_ready=1 for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; out_valid stays 1 with no bubbles.
- Backpressure:
  - Stimulus: req=4'b1010 held, out_ready=0 for 3 cycles after the first load.
  - Response: the first load takes requester 1 (ptr=0 reaches bit 1 first); out_data stays stable and gnt=0 for 3 cycles; when out_ready rises, requester 3 is granted and loaded in the same edge.
- Wrap-around: after granting requester 3 (ptr=0), req=4'b1001 -> requester 0 wins; then with req=4'b1001 again, requester 3 wins.
- Drain to empty: a single word loaded, then req=0 and out_ready=1 -> out_valid falls the next cycle and busy=0.
